pwm_channel_sequencer: RTL

Per-channel controller for one half-bridge leg of the PWM generator. It owns the carrier counter and duty compare, sequences the leg through bootstrap precharge, run, stop and fault states, and drives the two-bit gate request `SPDT` and the `DeadTimeCount` value into the downstream dead-time inserter. Configuration is double-buffered and applied only at period boundaries, so the dead-time inserter never sees a mid-period change of duty or dead time.

---
 rtl/pwm_pkg.sv | 11 +
 rtl/pwm_channel_sequencer_carrier.sv | 41 ++++
 rtl/pwm_channel_sequencer.sv | 107 ++++++++++
 3 files changed

// File: rtl/pwm_pkg.sv
// pwm_pkg: shared types and constants for the PWM channel sequencer
//   PWM_CNT_W   default width of period/duty/dead-time/precharge values
//   seq_state_t sequencer states
//   SPDT_*      gate request encodings (bit1 high side, bit0 low side)
package pwm_pkg;
    localparam int PWM_CNT_W = 16;
    typedef enum logic [2:0] {IDLE, PRECHARGE, RUN, STOPPING, FAULT} seq_state_t;
    localparam logic [1:0] SPDT_OFF = 2'b00;
    localparam logic [1:0] SPDT_HI  = 2'b10;
    localparam logic [1:0] SPDT_LO  = 2'b01;
endpackage

// File: rtl/pwm_channel_sequencer_carrier.sv
// pwm_carrier: carrier wrap counter with period clamp and duty compare
//   MClk, Rst  clock and synchronous active-high reset
//   Enable     carrier runs in the coming cycle
//   Period     active period of the current cycle (clamped to at least 2)
//   Duty       duty that applies to the coming cycle
//   Cnt        carrier count for the coming cycle (0 when not enabled or on entry)
//   Wrap       current cycle is the last of the period
//   HiSide     high side requested in the coming cycle
module pwm_carrier
    import pwm_pkg::*;
#(
    parameter int CNT_W = PWM_CNT_W
) (
    input  logic             MClk,
    input  logic             Rst,
    input  logic             Enable,
    input  logic [CNT_W-1:0] Period,
    input  logic [CNT_W-1:0] Duty,
    output logic [CNT_W-1:0] Cnt,
    output logic             Wrap,
    output logic             HiSide
);
    logic             run_q;
    logic [CNT_W-1:0] cnt_q, pa;
    always_comb begin
        pa = (Period < CNT_W'(2)) ? CNT_W'(2) : Period;
        Wrap = run_q && (cnt_q >= pa - CNT_W'(1));
        // a freshly enabled carrier always starts its first period at 0
        Cnt = (Enable && run_q && !Wrap) ? cnt_q + CNT_W'(1) : '0;
        HiSide = Cnt < Duty;
    end
    always_ff @(posedge MClk) begin
        if (Rst) begin
            run_q <= 1'b0;
            cnt_q <= '0;
        end else begin
            run_q <= Enable;
            cnt_q <= Cnt;
        end
    end
endmodule

// File: rtl/pwm_channel_sequencer.sv
// pwm_channel_sequencer: half-bridge leg sequencer with double-buffered carrier configuration
//   MClk, Rst            clock and synchronous active-high reset
//   Start, Stop          level start/stop requests
//   Fault, FaultClr      external trip and its acknowledge pulse
//   CfgWe, Cfg*          configuration write into the pending registers
//   SPDT                 gate request, DeadTimeCount active dead time
//   PeriodStart, Running, Faulted, CfgPending  registered status
module pwm_channel_sequencer
    import pwm_pkg::*;
#(
    parameter int CNT_W = PWM_CNT_W
) (
    input  logic             MClk,
    input  logic             Rst,
    input  logic             Start,
    input  logic             Stop,
    input  logic             Fault,
    input  logic             FaultClr,
    input  logic             CfgWe,
    input  logic [CNT_W-1:0] CfgPeriod,
    input  logic [CNT_W-1:0] CfgDuty,
    input  logic [CNT_W-1:0] CfgDeadTime,
    input  logic [CNT_W-1:0] CfgPrecharge,
    output logic [1:0]       SPDT,
    output logic [CNT_W-1:0] DeadTimeCount,
    output logic             PeriodStart,
    output logic             Running,
    output logic             Faulted,
    output logic             CfgPending
);
    seq_state_t       state, state_next;
    logic [CNT_W-1:0] pend_period, pend_duty, pend_dead, pend_pre;
    logic [CNT_W-1:0] act_period, act_duty, act_pre;
    logic [CNT_W-1:0] duty_next, pre_next, pre_cnt, cnt;
    logic             boundary, apply, wrap, hi_side, run_now, run_next;
    pwm_carrier #(.CNT_W(CNT_W)) u_carrier (
        .MClk   (MClk),
        .Rst    (Rst),
        .Enable (run_next),
        .Period (act_period),
        .Duty   (duty_next),
        .Cnt    (cnt),
        .Wrap   (wrap),
        .HiSide (hi_side)
    );
    always_comb begin
        run_now = state == RUN || state == STOPPING;
        boundary = state == IDLE || (run_now && wrap);
        apply = boundary && CfgPending;
        // values that are active in the coming cycle, seen through a boundary update
        duty_next = apply ? pend_duty : act_duty;
        pre_next = apply ? pend_pre : act_pre;
        state_next = state;
        if (Fault)
            state_next = FAULT;
        else
            case (state)
                IDLE:      if (Start) state_next = (pre_next == '0) ? RUN : PRECHARGE;
                PRECHARGE: state_next = Stop ? IDLE : (pre_cnt == CNT_W'(1)) ? RUN : PRECHARGE;
                RUN:       if (Stop) state_next = STOPPING;
                STOPPING:  if (wrap) state_next = IDLE;
                FAULT:     if (FaultClr) state_next = IDLE;
                default:   state_next = IDLE;
            endcase
        run_next = state_next == RUN || state_next == STOPPING;
    end
    always_ff @(posedge MClk) begin
        if (Rst) begin
            state <= IDLE;
            SPDT <= SPDT_OFF;
            PeriodStart <= 1'b0;
            Running <= 1'b0;
            Faulted <= 1'b0;
            CfgPending <= 1'b0;
            pend_period <= '0;
            pend_duty <= '0;
            pend_dead <= '0;
            pend_pre <= '0;
            act_period <= '0;
            act_duty <= '0;
            act_pre <= '0;
            DeadTimeCount <= '0;
            pre_cnt <= '0;
        end else begin
            state <= state_next;
            if (apply) begin
                act_period <= pend_period;
                act_duty <= pend_duty;
                act_pre <= pend_pre;
                DeadTimeCount <= pend_dead;
            end
            if (CfgWe) begin
                pend_period <= CfgPeriod;
                pend_duty <= CfgDuty;
                pend_dead <= CfgDeadTime;
                pend_pre <= CfgPrecharge;
            end
            CfgPending <= CfgWe || (CfgPending && !boundary);
            // loaded outside PRECHARGE so entry starts with the full precharge count
            pre_cnt <= (state == PRECHARGE) ? pre_cnt - CNT_W'(1) : pre_next;
            SPDT <= (state_next == PRECHARGE) ? SPDT_LO : !run_next ? SPDT_OFF : hi_side ? SPDT_HI : SPDT_LO;
            PeriodStart <= run_next && cnt == '0;
            Running <= run_next;
            Faulted <= state_next == FAULT;
        end
    end
endmodule
